// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative multiply/divide unit for the Execute stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run as a
// 33-cycle operation (32 shift steps plus one sign-fix/write cycle) in
// parallel with the pipeline. A later HI/LO-class instruction that reaches
// Execute while an operation is in flight stalls the front of the pipe.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU write HI/LO at the acceptance edge from a
//   single-cycle 64-bit multiply, and only divides use the iterative path.
module execute_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alu_control_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        flush_e,
  output logic        stall_e,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] result_e
);

  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_MULTU = 5'h11;
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_DIVU  = 5'h13;
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  localparam logic [4:0] OP_MTHI  = 5'h16;
  localparam logic [4:0] OP_MTLO  = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_res;      // product / quotient must be negated
  logic        r_neg_rem;      // remainder must be negated (dividend < 0)
  logic        r_div_zero;
  logic [31:0] r_dividend_raw; // HI value on divide by zero
  logic [31:0] r_mcand;        // multiplicand or divisor magnitude
  logic [31:0] r_acc_hi;       // product high half / partial remainder
  logic [31:0] r_acc_lo;       // multiplier bits / dividend bits -> quotient
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_md_op;
  logic        w_accept;
  logic        w_is_mul_code;
  logic        w_is_div_code;
  logic        w_signed_op;
  logic        w_start;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_fix_prod;
  logic [31:0] w_fix_quot;
  logic [31:0] w_fix_rem;

  assign busy     = (r_state != S_IDLE);
  assign w_md_op  = (alu_control_e[4:3] == 2'b10);
  assign stall_e  = busy & w_md_op & ~flush_e;
  assign w_accept = w_md_op & ~stall_e & ~flush_e;

  assign w_is_mul_code = (alu_control_e == OP_MULT) | (alu_control_e == OP_MULTU);
  assign w_is_div_code = (alu_control_e == OP_DIV)  | (alu_control_e == OP_DIVU);
  assign w_signed_op   = (alu_control_e == OP_MULT) | (alu_control_e == OP_DIV);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_fast_prod;
  assign w_start = w_accept & w_is_div_code;
  assign w_fast_prod = (alu_control_e == OP_MULT)
    ? $signed({{32{src_a_e[31]}}, src_a_e}) * $signed({{32{src_b_e[31]}}, src_b_e})
    : {32'd0, src_a_e} * {32'd0, src_b_e};
`else
  assign w_start = w_accept & (w_is_mul_code | w_is_div_code);
`endif

  // Signed ops iterate on magnitudes; signs are re-applied in FIX.
  assign w_a_mag = (w_signed_op & src_a_e[31]) ? (32'd0 - src_a_e) : src_a_e;
  assign w_b_mag = (w_signed_op & src_b_e[31]) ? (32'd0 - src_b_e) : src_b_e;

  // One shift-add step: add multiplicand when the current multiplier bit is
  // set, then shift the 64-bit {hi, lo} accumulator right by one.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : 33'd0);

  // One restoring-divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_sub   = w_div_shift[31:0] - r_mcand;

  assign w_fix_prod = r_neg_res ? (64'd0 - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
  assign w_fix_quot = r_neg_res ? (32'd0 - r_acc_lo) : r_acc_lo;
  assign w_fix_rem  = r_neg_rem ? (32'd0 - r_acc_hi) : r_acc_hi;

  // Sequencer and iterative datapath: IDLE -> MUL/DIV (32 steps) -> FIX.
  // NOTE: all state in clocked blocks uses non-blocking assignment so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_count        <= 5'd0;
      r_is_div       <= 1'b0;
      r_neg_res      <= 1'b0;
      r_neg_rem      <= 1'b0;
      r_div_zero     <= 1'b0;
      r_dividend_raw <= 32'd0;
      r_mcand        <= 32'd0;
      r_acc_hi       <= 32'd0;
      r_acc_lo       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_count        <= 5'd0;
            r_is_div       <= w_is_div_code;
            r_neg_res      <= w_signed_op & (src_a_e[31] ^ src_b_e[31]);
            r_neg_rem      <= w_signed_op & src_a_e[31];
            r_div_zero     <= (src_b_e == 32'd0);
            r_dividend_raw <= src_a_e;
            r_acc_hi       <= 32'd0;
            if (w_is_div_code) begin
              r_mcand  <= w_b_mag;
              r_acc_lo <= w_a_mag;
              r_state  <= S_DIV;
            end else begin
              r_mcand  <= w_a_mag;
              r_acc_lo <= w_b_mag;
              r_state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc_hi <= w_mul_sum[32:1];
          r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc_hi <= w_div_ge ? w_div_sub : w_div_shift[31:0];
          r_acc_lo <= {r_acc_lo[30:0], w_div_ge};
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Architectural HI/LO: written by FIX, by MTHI/MTLO, or by a fast multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == S_FIX) begin
      if (!r_is_div) begin
        r_hi <= w_fix_prod[63:32];
        r_lo <= w_fix_prod[31:0];
      end else if (r_div_zero) begin
        r_hi <= r_dividend_raw;
        r_lo <= 32'hFFFF_FFFF;
      end else begin
        r_hi <= w_fix_rem;
        r_lo <= w_fix_quot;
      end
    end else if (w_accept && alu_control_e == OP_MTHI) begin
      r_hi <= src_a_e;
    end else if (w_accept && alu_control_e == OP_MTLO) begin
      r_lo <= src_a_e;
`ifdef MULDIV_FAST_MUL_EN
    end else if (w_accept && w_is_mul_code) begin
      r_hi <= w_fast_prod[63:32];
      r_lo <= w_fast_prod[31:0];
`endif
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // MFHI/MFLO read port, zero for every other code.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    result_e = 32'd0;
    case (alu_control_e)
      OP_MFHI: result_e = r_hi;
      OP_MFLO: result_e = r_lo;
      default: result_e = 32'd0;
    endcase
  end

endmodule
